// File: rtl/tribus_pkg.sv
// Shared types and helpers for the tri-state line receiver.
package tribus_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } rx_state_t;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_TIMEOUT = 4;

    // Even-parity bit for a data word: 1 when the word holds an odd number of ones.
    function automatic logic even_parity(input logic [31:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/tribus_gap_timer.sv
// Counts consecutive undriven cycles inside a partial word and pulses
// timeout on the cycle the count reaches TIMEOUT.
module tribus_gap_timer #(
    parameter int TIMEOUT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic timeout
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

    logic [7:0] gap_reg;
    logic [7:0] gap_next;

    assign timeout = inc && !clr && (gap_reg == LIMIT);

    // Next gap count: restart on clear or expiry, otherwise count undriven cycles.
    always_comb begin
        gap_next = gap_reg;
        if (clr || timeout) begin
            gap_next = '0;
        end else if (inc) begin
            gap_next = gap_reg + 8'd1;
        end
    end

    // Gap count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            gap_reg <= '0;
        end else begin
            gap_reg <= gap_next;
        end
    end

endmodule

// File: rtl/tribus_line_rx.sv
// Receiver for a single-wire tri-state line: assembles MSB-first words while
// the driver is enabled and presents them on a valid/ready output register.
// Optional even-parity bit per word is enabled by defining TRIBUS_PARITY_EN.
module tribus_line_rx
    import tribus_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             line_en,
    input  logic             line_d,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             hold_q,
    output logic             overrun,
    output logic             frame_err,
    output logic             parity_err,
    input  logic             err_clr
);

`ifdef TRIBUS_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int            NBITS = WIDTH + PAR;
    localparam int            CW    = $clog2(NBITS + 1);
    localparam logic [CW-1:0] LAST  = CW'(NBITS - 1);

    rx_state_t        state_reg, state_next;
    logic [CW-1:0]    count_reg, count_next;
    logic [NBITS-1:0] shift_reg, shift_next, shift_in;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] data_reg, data_next;
    logic             valid_reg, valid_next;
    logic             hold_reg;
    logic             overrun_reg;
    logic             frame_err_reg;
    logic             complete, frame_abort, word_ok;
    logic             load, set_ovr;
    logic             gap_clr, gap_inc, gap_timeout;

    // Frame with the current line bit appended; the data word sits above any parity bit.
    assign shift_in = {shift_reg[NBITS-2:0], line_d};

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_word
            assign word[gi] = shift_in[gi + PAR];
        end
    endgenerate

`ifdef TRIBUS_PARITY_EN
    logic parity_err_reg;
    logic set_par;
    assign word_ok    = (even_parity(32'(word)) == shift_in[0]);
    assign set_par    = complete && !word_ok;
    assign parity_err = parity_err_reg;

    // Sticky parity error; a new failure wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_err_reg <= 1'b0;
        end else begin
            parity_err_reg <= set_par | (parity_err_reg & ~err_clr);
        end
    end
`else
    assign word_ok    = 1'b1;
    assign parity_err = 1'b0;
`endif

    // The gap timer only runs while a partial word is held and the driver is released.
    assign gap_inc = (state_reg == SHIFT) && !line_en;
    assign gap_clr = line_en || (state_reg == IDLE);

    tribus_gap_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_gap_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (gap_clr),
        .inc    (gap_inc),
        .timeout(gap_timeout)
    );

    // FSM next state: shift bits in, detect word completion and timeout aborts.
    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        shift_next  = shift_reg;
        complete    = 1'b0;
        frame_abort = 1'b0;
        case (state_reg)
            IDLE: begin
                if (line_en) begin
                    shift_next = shift_in;
                    count_next = CW'(1);
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (line_en) begin
                    if (count_reg == LAST) begin
                        complete   = 1'b1;
                        count_next = '0;
                        shift_next = '0;
                        state_next = IDLE;
                    end else begin
                        shift_next = shift_in;
                        count_next = count_reg + CW'(1);
                    end
                end else if (gap_timeout) begin
                    frame_abort = 1'b1;
                    count_next  = '0;
                    shift_next  = '0;
                    state_next  = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
                shift_next = '0;
            end
        endcase
    end

    // Output slot: a finished word loads if the slot is free or being consumed now.
    always_comb begin
        load       = complete && word_ok && (!valid_reg || out_ready);
        set_ovr    = complete && word_ok && valid_reg && !out_ready;
        data_next  = data_reg;
        valid_next = valid_reg;
        if (load) begin
            data_next  = word;
            valid_next = 1'b1;
        end else if (valid_reg && out_ready) begin
            valid_next = 1'b0;
        end
    end

    // State, datapath, keeper and sticky flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            shift_reg     <= '0;
            data_reg      <= '0;
            valid_reg     <= 1'b0;
            hold_reg      <= 1'b0;
            overrun_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            shift_reg     <= shift_next;
            data_reg      <= data_next;
            valid_reg     <= valid_next;
            if (line_en) begin
                hold_reg <= line_d;
            end
            overrun_reg   <= set_ovr | (overrun_reg & ~err_clr);
            frame_err_reg <= frame_abort | (frame_err_reg & ~err_clr);
        end
    end

    assign out_data  = data_reg;
    assign out_valid = valid_reg;
    assign hold_q    = hold_reg;
    assign overrun   = overrun_reg;
    assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_tribus_line_rx.sv
// Scoreboard bench for tribus_line_rx: directed scenarios followed by
// randomized line traffic, checked against a bit-queue reference model.
module tb_tribus_line_rx;

    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 4;
`ifdef TRIBUS_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NBITS = WIDTH + PAR;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             line_en = 1'b0;
    logic             line_d = 1'b0;
    logic             out_ready = 1'b0;
    logic             err_clr = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             hold_q;
    logic             overrun;
    logic             frame_err;
    logic             parity_err;

    tribus_line_rx #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .line_en   (line_en),
        .line_d    (line_d),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .hold_q    (hold_q),
        .overrun   (overrun),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: received bits of the partial frame, gap count, slot and flags.
    int m_bits[$];
    int m_gap  = 0;
    bit m_full = 0;
    bit m_hold = 0;
    bit m_ovr  = 0;
    bit m_fe   = 0;
    bit m_pe   = 0;
    int exp_q[$];
    bit mon_on = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one clock edge worth of behaviour to the model.
    task automatic model_edge(input bit en, input bit d, input bit rdy, input bit clr, input bit r);
        bit consumed, load, ovr_s, fe_s, pe_s, ok;
        int val;
        if (r) begin
            m_bits.delete();
            exp_q.delete();
            m_gap = 0; m_full = 0; m_hold = 0;
            m_ovr = 0; m_fe = 0; m_pe = 0;
            return;
        end
        consumed = m_full && rdy;
        load = 0; ovr_s = 0; fe_s = 0; pe_s = 0;
        if (en) begin
            m_hold = d;
            m_gap  = 0;
            m_bits.push_back(int'(d));
            if (m_bits.size() == NBITS) begin
                val = 0;
                foreach (m_bits[i]) val = val * 2 + m_bits[i];
                m_bits.delete();
                ok = (PAR == 0) || (($countones(val) % 2) == 0);
                if (!ok) pe_s = 1;
                else if (!m_full || rdy) begin
                    load = 1;
                    exp_q.push_back(val >> PAR);
                end else ovr_s = 1;
            end
        end else if (m_bits.size() > 0) begin
            m_gap++;
            if (m_gap >= TIMEOUT) begin
                m_bits.delete();
                m_gap = 0;
                fe_s = 1;
            end
        end
        m_full = load ? 1'b1 : (consumed ? 1'b0 : m_full);
        m_ovr  = ovr_s | (m_ovr & ~clr);
        m_fe   = fe_s  | (m_fe  & ~clr);
        m_pe   = pe_s  | (m_pe  & ~clr);
    endtask

    task automatic step(input bit en, input bit d, input bit rdy, input bit clr = 0, input bit r = 0);
        rst = r; line_en = en; line_d = d; out_ready = rdy; err_clr = clr;
        @(posedge clk);
        model_edge(en, d, rdy, clr, r);
        #1;
    endtask

    // Send a data word plus an explicit parity bit (ignored without parity).
    task automatic send_raw(input logic [WIDTH-1:0] w, input bit pbit, input bit rdy, input bit rdy_last);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            step(1'b1, w[i], (PAR == 0 && i == 0) ? rdy_last : rdy);
        end
        if (PAR != 0) step(1'b1, pbit, rdy_last);
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w, input bit rdy, input bit rdy_last);
        send_raw(w, ^w, rdy, rdy_last);
    endtask

    // Monitor: compare state against the model and pop the scoreboard on every handshake.
    always @(negedge clk) begin
        if (mon_on && !rst) begin
            check("out_valid", out_valid, m_full);
            check("hold_q", hold_q, m_hold);
            check("overrun", overrun, m_ovr);
            check("frame_err", frame_err, m_fe);
            check("parity_err", parity_err, m_pe);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_word: got %0h, expected no word", out_data);
                end else begin
                    check("out_data", out_data, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        // Reset state
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        check("rst_out_data", out_data, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_hold_q", hold_q, 0);
        check("rst_flags", {overrun, frame_err, parity_err}, 0);
        mon_on = 1;

        // Basic word, one clock latency from the last bit
        send_word(8'hA5, 1, 1);
        check("basic_valid", out_valid, 1);
        check("basic_data", out_data, 8'hA5);
        step(0, 0, 1);

        // Keeper holds the last driven level across a short gap
        step(1, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 1, 1);
        check("keeper_hold", hold_q, 0);
        check("keeper_fe", frame_err, 0);
        for (int i = 0; i < 7; i++) step(1, 1, 1);
        if (PAR != 0) step(1, 1, 1);
        check("keeper_data", out_data, 8'h7F);

        // Timeout aborts a partial word
        step(1, 1, 1); step(1, 0, 1); step(1, 1, 1);
        for (int i = 0; i < TIMEOUT; i++) step(0, 0, 1);
        check("timeout_fe", frame_err, 1);
        check("timeout_valid", out_valid, 0);
        send_word(8'h3C, 1, 1);
        check("timeout_next", out_data, 8'h3C);
        step(0, 0, 1, 1);
        check("fe_clear", frame_err, 0);

        // Overrun with a stalled consumer
        send_word(8'h11, 0, 0);
        send_word(8'h22, 0, 0);
        check("ovr_data", out_data, 8'h11);
        check("ovr_flag", overrun, 1);
        step(0, 0, 1);
        check("ovr_drain", out_valid, 0);
        step(0, 0, 0, 1);
        check("ovr_clear", overrun, 0);

        // Consume and load in the same cycle
        send_word(8'h11, 0, 0);
        step(0, 0, 0);
        send_word(8'h33, 0, 1);
        check("simul_valid", out_valid, 1);
        check("simul_data", out_data, 8'h33);
        check("simul_ovr", overrun, 0);
        step(0, 0, 1);

`ifdef TRIBUS_PARITY_EN
        send_raw(8'h01, 1'b1, 1, 1);
        check("par_ok_data", out_data, 8'h01);
        check("par_ok_valid", out_valid, 1);
        step(0, 0, 1);
        send_raw(8'h01, 1'b0, 1, 1);
        check("par_bad_flag", parity_err, 1);
        check("par_bad_valid", out_valid, 0);
        step(0, 0, 1, 1);
`endif

        // Reset in the middle of a word
        send_word(8'h5A, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 1, 0);
        step(0, 0, 0, 0, 1);
        check("midrst_valid", out_valid, 0);
        check("midrst_data", out_data, 0);
        check("midrst_hold", hold_q, 0);
        send_word(8'hFF, 1, 1);
        check("midrst_next", out_data, 8'hFF);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            step(($urandom_range(0, 9) < 7), 1'($urandom), ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 49) == 0), ($urandom_range(0, 599) == 0));
        end

        // Drain: every delivered word must have been consumed
        for (int i = 0; i < 2 * TIMEOUT + 4; i++) step(0, 0, 1);
        check("drain_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tribus_line_rx.md
Name: tribus_line_rx

Overview:
- Receive end of a single-wire tri-state line driven by a transmission-gate driver, where the driver enable and data are both visible to the receiver.
- While the driver enables the line, the block samples one bit per clock MSB-first and assembles WIDTH-bit words.
- Completed words are presented on a valid/ready output register.
- Also provides a bus-keeper value (last driven level) and detects overrun and aborted frames (driver released mid-word too long).

Parameters:
- WIDTH, 8, data bits per word (2..32).
- TIMEOUT, 4, maximum consecutive undriven cycles tolerated inside a partial word (1..255).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- line_en  input  1  driver enable (transmission-gate control); 1 = line driven this cycle.
- line_d  input  1  line data level; meaningful only when line_en=1.
- out_data  output  WIDTH  received word.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  consumer accepts out_data when out_valid & out_ready.
- hold_q  output  1  bus-keeper: last sampled driven level.
- overrun  output  1  sticky: word completed while the output slot was full.
- frame_err  output  1  sticky: partial word aborted by timeout.
- parity_err  output  1  sticky parity failure (see Optional Feature).
- err_clr  input  1  clears all sticky flags.

Behaviour:
- Reset values: all outputs 0, state IDLE, bit count 0, gap count 0, shift register 0.
- FSM states:
  - IDLE: no bits held. line_en=1 -> shift in line_d, count=1, go SHIFT (or deliver immediately if the word completes, WIDTH not <2).
  - SHIFT: line_en=1 -> shift in line_d, count+1, gap count cleared. line_en=0 -> gap count+1; gap count reaching TIMEOUT -> discard partial word, frame_err<=1, go IDLE.
- Word completion: occurs on the cycle the final bit is sampled; count returns to 0, state goes to IDLE.
  - If out_valid=0, or out_valid&out_ready in the same cycle, then out_data<=word and out_valid<=1 on the next edge. Latency is 1 clock from the last bit.
  - Otherwise the new word is dropped, overrun<=1, and the old out_data is kept.
- out_valid falls on the edge after out_valid&out_ready, unless a new word loads in that same cycle; in that case it stays 1 with the new data.
- hold_q<=line_d on every cycle with line_en=1; held while line_en=0. Independent of the FSM.
- err_clr: clears all sticky flags next edge. If err_clr and a new error occur in the same cycle, set wins.
- Back-to-back words need no idle cycle between them.
- Mid-operation rst: discards the partial word and the output word. No output is generated from reset.

Optional Feature:
- Macro: TRIBUS_PARITY_EN.
- With the macro: one extra even-parity bit follows the WIDTH data bits; the word completes on the parity bit.
  - Parity mismatch: word dropped, parity_err<=1, out_valid unaffected.
  - Parity bit absent at timeout: counts as frame_err.
- Without the macro: no parity bit is expected and parity_err is tied 0.

Decomposition:
- Package tribus_pkg: FSM state enum (IDLE, SHIFT), default WIDTH/TIMEOUT constants, parity helper function.
- One natural sub-module, tribus_gap_timer: gap counter with clear, increment, and timeout pulse.

Test Plan (WIDTH=8, TIMEOUT=4):
- Basic word: rst, then drive 0xA5 MSB-first on 8 consecutive cycles with out_ready=1 -> out_valid=1 one clock after the 8th bit, out_data=0xA5, hold_q=1, no flags.
- Keeper: drive a single 0 bit, then line_en=0 for 3 cycles -> hold_q stays 0, frame_err=0. Then 7 more bits 1111111 -> out_data=0x7F.
- Timeout: 3 bits, then line_en=0 for 4 cycles -> frame_err=1, nothing output. Next 8 bits 0x3C -> out_data=0x3C.
- Overrun: out_ready=0, send 0x11 then 0x22 back-to-back -> out_data=0x11, overrun=1. Then out_ready=1 -> out_valid drops one edge later. err_clr -> overrun=0.
- Simultaneous: out_valid=1 with 0x11, and out_ready=1 on the cycle 0x33 completes -> out_valid stays 1, out_data=0x33, overrun=0.
- Parity (TRIBUS_PARITY_EN): 0x01 with parity bit 1 -> accepted; 0x01 with parity bit 0 -> parity_err=1, no word.
- Reset mid-word: rst after 5 bits -> all outputs 0; a fresh 0xFF afterward is received correctly.
